// File: rtl/id_ex_register_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle layout, field indices and opcodes.
package id_ex_register_pkg;

  localparam int unsigned CTRL_W = 12;

  // Bit positions of each field inside the flat control bundle
  localparam int unsigned CTRL_BRANCH_EQ   = 11;
  localparam int unsigned CTRL_BRANCH_NE   = 10;
  localparam int unsigned CTRL_ALU_OP_HI   = 9;
  localparam int unsigned CTRL_ALU_OP_LO   = 8;
  localparam int unsigned CTRL_MEM_READ    = 7;
  localparam int unsigned CTRL_MEM_WRITE   = 6;
  localparam int unsigned CTRL_MEM_TO_REG  = 5;
  localparam int unsigned CTRL_REG_DST     = 4;
  localparam int unsigned CTRL_REG_WRITE   = 3;
  localparam int unsigned CTRL_ALU_SRC     = 2;
  localparam int unsigned CTRL_SHIFT_UPPER = 1;
  localparam int unsigned CTRL_JUMP        = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] alu_opcode;
    logic       memory_read;
    logic       memory_write;
    logic       memory_to_register;
    logic       register_destination;
    logic       register_write;
    logic       alu_source;
    logic       shift_upper;
    logic       jump;
  } ctrl_t;

  // True when the instruction reads rt as a source operand
  function automatic logic uses_rt(input ctrl_t c);
    return c.register_destination | c.memory_write | c.branch_eq | c.branch_ne;
  endfunction

endpackage

// File: rtl/id_ex_register_load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the rt of a load sitting in EX.
module id_ex_register_load_use_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  haz
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (ex_rt == id_rs);
  assign w_rt_match = id_uses_rt & (ex_rt == id_rt);

  // $0 is hardwired to zero, so a load into it never creates a dependency
  assign haz = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional statistics counters are enabled by defining ID_EX_STATS_EN.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  ex_valid,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [5:0]            ex_funct,
`ifdef ID_EX_STATS_EN
  output logic [STAT_W-1:0]     stat_bubbles,
  output logic [STAT_W-1:0]     stat_holds,
`endif
  output logic                  load_use_stall
);

  ctrl_t                 w_id_ctrl;
  logic                  w_haz;
  logic                  w_bubble;

  logic                  r_valid,    w_valid_nxt;
  ctrl_t                 r_ctrl,     w_ctrl_nxt;
  logic [DATA_W-1:0]     r_pc_plus4;
  logic [DATA_W-1:0]     r_rs_data;
  logic [DATA_W-1:0]     r_rt_data;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [5:0]            r_funct;

  assign w_id_ctrl = ctrl_t'(id_ctrl);

  id_ex_register_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (uses_rt(w_id_ctrl)),
    .ex_valid    (r_valid),
    .ex_mem_read (r_ctrl.memory_read),
    .ex_rt       (r_rt),
    .haz         (w_haz)
  );

  // Hold outranks everything, flush outranks the hazard
  assign load_use_stall = w_haz & ~flush & ~hold;
  assign w_bubble       = flush | load_use_stall;

  // Next valid/control; an invalid slot always carries an all-zero bundle
  always_comb begin
    w_valid_nxt = r_valid;
    w_ctrl_nxt  = r_ctrl;
    if (!hold) begin
      if (w_bubble || !id_valid) begin
        w_valid_nxt = 1'b0;
        w_ctrl_nxt  = '0;
      end else begin
        w_valid_nxt = 1'b1;
        w_ctrl_nxt  = w_id_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc_plus4 <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_ctrl  <= w_ctrl_nxt;
      // Data fields are don't-care under a bubble, so they load whenever not held
      if (!hold) begin
        r_pc_plus4 <= id_pc_plus4;
        r_rs_data  <= id_rs_data;
        r_rt_data  <= id_rt_data;
        r_imm      <= id_imm;
        r_rs       <= id_rs;
        r_rt       <= id_rt;
        r_rd       <= id_rd;
        r_funct    <= id_funct;
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_ctrl     = CTRL_W'(r_ctrl);
  assign ex_pc_plus4 = r_pc_plus4;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm      = r_imm;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_funct    = r_funct;

`ifdef ID_EX_STATS_EN
  logic [STAT_W-1:0] r_stat_bubbles;
  logic [STAT_W-1:0] r_stat_holds;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_bubbles <= '0;
      r_stat_holds   <= '0;
    end else begin
      if (!hold && w_bubble && !(&r_stat_bubbles)) begin
        r_stat_bubbles <= r_stat_bubbles + STAT_W'(1);
      end
      if (hold && !(&r_stat_holds)) begin
        r_stat_holds <= r_stat_holds + STAT_W'(1);
      end
    end
  end

  assign stat_bubbles = r_stat_bubbles;
  assign stat_holds   = r_stat_holds;
`endif

endmodule
